// File: rtl/snn_input_ctrl_if.sv
// Handshake bundle between the SNN input-frame controller, its UART source,
// the bit-addressed input memory and the layer-1 engine.
interface snn_input_ctrl_if #(
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 10
);
  logic              rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [BYTE_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_q;
  logic              bit_valid;
  logic              bit_ready;
  logic              bit_data;
  logic [ADDR_W-1:0] bit_idx;
  logic              frame_done;
  logic              done_ack;
  logic              busy;
  logic              overrun;

  modport master (
    input  rx_rdy, rx_data, mem_q, bit_ready, done_ack,
    output mem_we, mem_waddr, mem_wdata, mem_raddr, bit_valid, bit_data, bit_idx,
           frame_done, busy, overrun
  );

  modport slave (
    output rx_rdy, rx_data, mem_q, bit_ready, done_ack,
    input  mem_we, mem_waddr, mem_wdata, mem_raddr, bit_valid, bit_data, bit_idx,
           frame_done, busy, overrun
  );
endinterface

// File: rtl/snn_input_ctrl.sv
// Input-frame controller: packs UART bytes into the 1-bit pixel memory, then
// streams the frame to the layer-1 engine through a 2-entry prefetch FIFO.
module snn_input_ctrl #(
  parameter int NUM_BITS = 784,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 10
) (
  input  logic            clk,
  input  logic            rst,
  snn_input_ctrl_if.master bus
);
  localparam int NUM_BYTES = NUM_BITS / BYTE_W;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W:0]   END_PTR   = (ADDR_W+1)'(NUM_BITS);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_BITS - 1);
  localparam logic [ADDR_W-1:0] BYTE_STEP = ADDR_W'(BYTE_W);

  typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic [ADDR_W:0]    rd_ptr_q;
  logic [ADDR_W-1:0]  raddr_q;
  logic               overrun_q;
  logic               vld_p1;
  logic [ADDR_W-1:0]  idx_p1;
  logic [1:0]         fifo_cnt_q;
  logic [1:0]         fifo_bit_q;
  logic [ADDR_W-1:0]  fifo_idx_q [2];

  logic       wr_en, bit_vld, pop, push, issue, last_pop;
  logic [1:0] occ, slot;

  always_comb begin
    wr_en    = bus.rx_rdy && (state_q == LOAD);
    bit_vld  = (state_q == SCAN) && (fifo_cnt_q != 2'd0);
    pop      = bit_vld && bus.bit_ready;
    push     = vld_p1;
    last_pop = pop && (fifo_idx_q[0] == LAST_IDX);
    occ      = fifo_cnt_q + {1'b0, vld_p1};
    slot     = fifo_cnt_q - {1'b0, pop};
    // an in-flight read already owns a FIFO slot, so count it as occupied
    issue    = (state_q == SCAN) && (rd_ptr_q < END_PTR) && (occ < (2'd2 + {1'b0, pop}));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (wr_en && (byte_cnt_q == LAST_BYTE)) state_d = SCAN;
      SCAN:    if (last_pop) state_d = DONE;
      DONE:    if (bus.done_ack) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      byte_cnt_q <= '0;
      rd_ptr_q   <= '0;
      raddr_q    <= '0;
      overrun_q  <= 1'b0;
      vld_p1     <= 1'b0;
      fifo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.rx_rdy && (state_q != LOAD)) overrun_q <= 1'b1;
      if (wr_en) byte_cnt_q <= byte_cnt_q + CNT_W'(1);
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
        raddr_q  <= rd_ptr_q[ADDR_W-1:0];
      end
      vld_p1     <= issue;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      if ((state_q == DONE) && bus.done_ack) begin
        byte_cnt_q <= '0;
        rd_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end
    end
  end

  // ---- stage p1 -> FIFO: memory read data joins its index ----
  always_ff @(posedge clk) begin
    if (issue) idx_p1 <= rd_ptr_q[ADDR_W-1:0];
    if (pop) begin
      fifo_bit_q[0] <= fifo_bit_q[1];
      fifo_idx_q[0] <= fifo_idx_q[1];
    end
    if (push) begin
      if (slot == 2'd0) begin
        fifo_bit_q[0] <= bus.mem_q;
        fifo_idx_q[0] <= idx_p1;
      end else begin
        fifo_bit_q[1] <= bus.mem_q;
        fifo_idx_q[1] <= idx_p1;
      end
    end
  end

  assign bus.mem_we     = wr_en;
  assign bus.mem_waddr  = ADDR_W'(byte_cnt_q) * BYTE_STEP;
  assign bus.mem_wdata  = wr_en ? bus.rx_data : '0;
  assign bus.mem_raddr  = issue ? rd_ptr_q[ADDR_W-1:0] : raddr_q;
  assign bus.bit_valid  = bit_vld;
  assign bus.bit_data   = bit_vld & fifo_bit_q[0];
  assign bus.bit_idx    = bit_vld ? fifo_idx_q[0] : '0;
  assign bus.frame_done = (state_q == DONE);
  assign bus.busy       = (state_q != LOAD);
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_snn_input_ctrl.sv
// Directed bench for snn_input_ctrl: behavioural pixel memory, stream
// scoreboard, a table of frame scenarios and hand-written corner sequences.
module tb_snn_input_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snn_input_ctrl_if #(.BYTE_W(8), .ADDR_W(10)) bus ();
  snn_input_ctrl #(.NUM_BITS(784), .BYTE_W(8), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic mem_bits [0:1023];
  always @(posedge clk) begin
    if (bus.mem_we)
      for (int i = 0; i < 8; i++) mem_bits[int'(bus.mem_waddr) + i] <= bus.mem_wdata[i];
    bus.mem_q <= mem_bits[bus.mem_raddr];
  end

  int n_chk = 0, n_pass = 0;
  int wr_err = 0, exp_waddr = 0, base = 0;
  logic [7:0] cur_pat = 8'h00;

  // scoreboard counters, written only by the monitor
  int pop_total = 0, str_err = 0, hold_err = 0, excl_err = 0, we_total = 0;
  logic prev_stall = 1'b0, prev_data = 1'b0;
  logic [9:0] prev_idx = '0;

  always @(negedge clk) begin
    if (bus.mem_we) we_total <= we_total + 1;
    if ((bus.frame_done && bus.bit_valid) || (bus.mem_we && bus.busy)) excl_err <= excl_err + 1;
    if (bus.bit_valid && bus.bit_ready) begin
      if (bus.bit_idx != 10'(pop_total - base) || bus.bit_data != cur_pat[(pop_total - base) % 8])
        str_err <= str_err + 1;
      pop_total <= pop_total + 1;
    end
    if (prev_stall && (!bus.bit_valid || bus.bit_idx != prev_idx || bus.bit_data != prev_data))
      hold_err <= hold_err + 1;
    prev_stall <= bus.bit_valid && !bus.bit_ready;
    prev_idx   <= bus.bit_idx;
    prev_data  <= bus.bit_data;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.rx_rdy = 1'b0; bus.rx_data = '0; bus.done_ack = 1'b0; bus.bit_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b; bus.rx_rdy = 1'b1;
    @(negedge clk);
    if (bus.mem_we !== 1'b1 || bus.mem_waddr !== 10'(exp_waddr) || bus.mem_wdata !== b) wr_err++;
    exp_waddr += 8;
    tick();
    bus.rx_rdy = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] pat);
    base = pop_total; cur_pat = pat; exp_waddr = 0; wr_err = 0;
  endtask

  task automatic load_frame(input logic [7:0] pat, input int gap, input bit chk_busy);
    for (int i = 0; i < 98; i++) begin
      if (chk_busy && i == 97) chk("busy_before_last_byte", bus.busy, 0);
      send_byte(pat);
      if (i < 97) repeat (gap) tick();
    end
    if (chk_busy) chk("busy_at_last_byte", bus.busy, 1);
  endtask

  task automatic run_scan(input int stall_at, input int stall_len, input int inject_at,
                          input int ack_at, output int first_v, output int vcyc, output bit tout);
    int cyc = 0, left = 0;
    bit stalled = 0, injected = 0, acked = 0;
    first_v = -1; vcyc = 0; tout = 0;
    bus.bit_ready = 1'b1;
    while (!bus.frame_done) begin
      if (cyc >= 3000) begin tout = 1; break; end
      bus.rx_rdy = 1'b0; bus.done_ack = 1'b0;
      if (left > 0) begin left--; if (left == 0) bus.bit_ready = 1'b1; end
      if (bus.bit_valid) begin
        if (first_v < 0) first_v = cyc;
        vcyc++;
        if (!stalled && int'(bus.bit_idx) == stall_at) begin
          stalled = 1; left = stall_len; bus.bit_ready = 1'b0;
        end
        if (!injected && int'(bus.bit_idx) == inject_at) begin
          injected = 1; bus.rx_rdy = 1'b1; bus.rx_data = 8'h3C;
        end
        if (!acked && int'(bus.bit_idx) == ack_at) begin acked = 1; bus.done_ack = 1'b1; end
      end
      tick();
      cyc++;
    end
    bus.rx_rdy = 1'b0; bus.done_ack = 1'b0; bus.bit_ready = 1'b1;
  endtask

  task automatic finish_frame(input string tag);
    chk({tag, "_frame_done"}, bus.frame_done, 1);
    chk({tag, "_valid_in_done"}, bus.bit_valid, 0);
    bus.done_ack = 1'b1; tick(); bus.done_ack = 1'b0;
    chk({tag, "_busy_after_ack"}, bus.busy, 0);
    chk({tag, "_done_after_ack"}, bus.frame_done, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
    chk({tag, "_bit_valid"}, bus.bit_valid, 0);
    chk({tag, "_bit_data"}, bus.bit_data, 0);
    chk({tag, "_bit_idx"}, bus.bit_idx, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_waddr"}, bus.mem_waddr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_raddr"}, bus.mem_raddr, 0);
  endtask

  typedef struct {
    logic [7:0] pat;
    int stall_at;
    int stall_len;
    int inject_at;
    int ack_at;
    int exp_vcyc;
    int exp_ovr;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int fv, vc, we0, se0, he0, xe0, found;
    bit to;

    vecs[0] = '{8'hA5,  -1,  0,  -1,  -1, 784, 0};
    vecs[1] = '{8'h5A, 300, 10,  -1,  -1, 794, 0};
    vecs[2] = '{8'h81,  -1,  0, 100,  -1, 784, 1};
    vecs[3] = '{8'h00, 783, 10,  -1, 200, 794, 0};
    vecs[4] = '{8'hFF,   0,  3,  50, 400, 787, 1};

    do_reset();
    chk_all_zero("reset");

    // bytes spaced 50 cycles; busy must rise exactly at the 98th strobe
    start_frame(8'hFF); we0 = we_total;
    load_frame(8'hFF, 49, 1);
    chk("t1_writes", we_total - we0, 98);
    chk("t1_waddr_wdata_errs", wr_err, 0);
    run_scan(-1, 0, -1, -1, fv, vc, to);
    chk("t1_scan_timeout", to, 0);
    finish_frame("t1");

    for (int r = 0; r < 5; r++) begin
      do_reset();
      start_frame(vecs[r].pat);
      we0 = we_total; se0 = str_err; he0 = hold_err; xe0 = excl_err;
      load_frame(vecs[r].pat, 0, 0);
      run_scan(vecs[r].stall_at, vecs[r].stall_len, vecs[r].inject_at, vecs[r].ack_at, fv, vc, to);
      chk($sformatf("v%0d_timeout", r), to, 0);
      chk($sformatf("v%0d_writes", r), we_total - we0, 98);
      chk($sformatf("v%0d_waddr_errs", r), wr_err, 0);
      chk($sformatf("v%0d_first_valid_lat", r), fv, 2);
      chk($sformatf("v%0d_valid_cycles", r), vc, vecs[r].exp_vcyc);
      chk($sformatf("v%0d_bits_consumed", r), pop_total - base, 784);
      chk($sformatf("v%0d_stream_errs", r), str_err - se0, 0);
      chk($sformatf("v%0d_hold_errs", r), hold_err - he0, 0);
      chk($sformatf("v%0d_excl_errs", r), excl_err - xe0, 0);
      chk($sformatf("v%0d_overrun", r), bus.overrun, vecs[r].exp_ovr);
      finish_frame($sformatf("v%0d", r));
    end

    // done_ack and a stray byte in the same DONE cycle
    do_reset();
    start_frame(8'hA5);
    load_frame(8'hA5, 0, 0);
    run_scan(-1, 0, -1, -1, fv, vc, to);
    chk("t5_timeout", to, 0);
    chk("t5_overrun_before", bus.overrun, 0);
    chk("t5_in_done", bus.frame_done, 1);
    bus.done_ack = 1'b1; bus.rx_rdy = 1'b1; bus.rx_data = 8'h77;
    @(negedge clk);
    chk("t5_no_we_on_drop", bus.mem_we, 0);
    tick();
    bus.done_ack = 1'b0; bus.rx_rdy = 1'b0;
    chk("t5_busy", bus.busy, 0);
    chk("t5_frame_done", bus.frame_done, 0);
    chk("t5_overrun", bus.overrun, 1);
    start_frame(8'h11);
    send_byte(8'h11);
    chk("t5_next_byte_at_0", wr_err, 0);

    // reset in the middle of a scan
    do_reset();
    start_frame(8'hA5);
    load_frame(8'hA5, 0, 0);
    bus.rx_rdy = 1'b1; bus.rx_data = 8'h3C;
    tick();
    bus.rx_rdy = 1'b0;
    chk("t6_overrun_set", bus.overrun, 1);
    found = 0;
    for (int k = 0; k < 1000 && found == 0; k++) begin
      if (bus.bit_valid && bus.bit_idx == 10'd500) found = 1;
      else tick();
    end
    chk("t6_reach_idx500", found, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_all_zero("t6_rst");
    start_frame(8'hC3);
    se0 = str_err;
    load_frame(8'hC3, 0, 0);
    chk("t6_reload_waddr_errs", wr_err, 0);
    run_scan(-1, 0, -1, -1, fv, vc, to);
    chk("t6_timeout", to, 0);
    chk("t6_valid_cycles", vc, 784);
    chk("t6_bits_consumed", pop_total - base, 784);
    chk("t6_stream_errs", str_err - se0, 0);
    finish_frame("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
